instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 130 +++++++++++++
 tb/tb_instr_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 16-bit words from a small program memory and issues
// them one at a time to a processor, either free-running or one per Step press.
module instr_sequencer #(
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Step,
   input  logic              Auto,
   input  logic              Done,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [15:0]       WrData,
   output logic [15:0]       Instr,
   output logic              Run,
   output logic [ADDR_W-1:0] PC,
   output logic              Busy,
   output logic              Halted,
   output logic              Timeout
);

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam int         CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [2:0] OP_HALT  = 3'b111;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       instr_q, instr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              timeout_q, timeout_d;
   logic              sync1_q, sync2_q, step_prev_q;
   logic              step_req;
   logic              mem_we;
   logic [15:0]       fetch_word;
   logic [15:0]       mem [DEPTH];

   // Two-flop synchronizer for the asynchronous button, then a rising-edge detector.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         step_prev_q <= 1'b0;
      end else begin
         sync1_q     <= Step;
         sync2_q     <= sync1_q;
         step_prev_q <= sync2_q;
      end
   end

   assign step_req = sync2_q & ~step_prev_q;

   assign mem_we = WrEn && ((state_q == IDLE) || (state_q == HALT));

   // NOTE: program memory has no reset so its contents survive Reset and map onto RAM.
   always_ff @(posedge Clock) begin
      if (mem_we) begin
         mem[WrAddr] <= WrData;
      end
   end

   // Forward a same-cycle write to the fetch address so it is issued immediately.
   assign fetch_word = (mem_we && (WrAddr == pc_q)) ? WrData : mem[pc_q];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         instr_q   <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // NOTE: every next-state signal gets its hold value first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: begin
            if (Auto || step_req) begin
               instr_d = fetch_word;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (Done) begin
               pc_d    = pc_q + ADDR_W'(1);
               cnt_d   = '0;
               state_d = (instr_q[15:13] == OP_HALT) ? HALT : IDLE;
            end else if (cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
               state_d   = HALT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign Instr   = instr_q;
   assign PC      = pc_q;
   assign Run     = (state_q == ISSUE);
   assign Busy    = (state_q == ISSUE) || (state_q == WAIT);
   assign Halted  = (state_q == HALT);
   assign Timeout = timeout_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a cycle-level reference model compared on
// every falling edge, plus directed scenarios with hand-computed expectations.
module tb_instr_sequencer;

   localparam int ADDR_W  = 4;
   localparam int TIMEOUT = 255;

   logic        Clock = 1'b0;
   logic        Reset, Step, Auto, Done, WrEn;
   logic [3:0]  WrAddr;
   logic [15:0] WrData;
   logic [15:0] Instr;
   logic        Run, Busy, Halted, Timeout;
   logic [3:0]  PC;

   int checks = 0;
   int errors = 0;
   int run_cnt = 0;
   int base;
   bit resp_en = 1'b0;
   bit cmp_en  = 1'b0;

   always #5 Clock = ~Clock;

   instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Step   (Step),
      .Auto   (Auto),
      .Done   (Done),
      .WrEn   (WrEn),
      .WrAddr (WrAddr),
      .WrData (WrData),
      .Instr  (Instr),
      .Run    (Run),
      .PC     (PC),
      .Busy   (Busy),
      .Halted (Halted),
      .Timeout(Timeout)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: where the current instruction is in its life, plus architectural state.
   typedef enum {M_IDLE, M_RUN, M_WAIT, M_HALT} mphase_t;
   mphase_t     m_ph;
   logic [15:0] m_mem [16];
   logic [15:0] m_instr;
   logic [3:0]  m_pc;
   int          m_waited;
   bit          m_to;
   bit          m_s1, m_s2, m_s3;

   always @(posedge Clock or posedge Reset) begin
      bit req, wr_ok;
      if (Reset) begin
         m_ph = M_IDLE; m_pc = '0; m_instr = '0; m_waited = 0; m_to = 1'b0;
         m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
      end else begin
         req   = m_s2 && !m_s3;
         m_s3  = m_s2; m_s2 = m_s1; m_s1 = Step;
         wr_ok = WrEn && (m_ph == M_IDLE || m_ph == M_HALT);
         case (m_ph)
            M_IDLE: if (Auto || req) begin
               m_instr = (wr_ok && WrAddr == m_pc) ? WrData : m_mem[m_pc];
               m_ph    = M_RUN;
            end
            M_RUN: begin
               m_ph = M_WAIT; m_waited = 0;
            end
            M_WAIT: if (Done) begin
               m_pc = m_pc + 4'd1;
               m_ph = (m_instr[15:13] == 3'b111) ? M_HALT : M_IDLE;
            end else begin
               m_waited++;
               if (m_waited == TIMEOUT) begin m_to = 1'b1; m_ph = M_HALT; end
            end
            default: ;
         endcase
         if (wr_ok) m_mem[WrAddr] = WrData;
      end
   end

   always @(negedge Clock) begin
      if (cmp_en && !Reset) begin
         check("m_run",     32'(Run),     32'(m_ph == M_RUN));
         check("m_busy",    32'(Busy),    32'(m_ph == M_RUN || m_ph == M_WAIT));
         check("m_halted",  32'(Halted),  32'(m_ph == M_HALT));
         check("m_timeout", 32'(Timeout), 32'(m_to));
         check("m_pc",      32'(PC),      32'(m_pc));
         check("m_instr",   32'(Instr),   32'(m_instr));
      end
   end

   always @(negedge Clock) if (!Reset && Run) run_cnt++;

   // Processor stand-in: Done two cycles after each Run when enabled.
   initial begin
      Done = 1'b0;
      forever begin
         @(negedge Clock);
         if (resp_en && Run) begin
            @(posedge Clock); #1;
            @(posedge Clock); #1; Done = 1'b1;
            @(posedge Clock); #1; Done = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge Clock); #1; end
   endtask

   task automatic wr(input int a, input logic [15:0] d);
      WrEn = 1'b1; WrAddr = 4'(a); WrData = d;
      tick(1);
      WrEn = 1'b0;
   endtask

   task automatic pulse_step();
      Step = 1'b1; tick(4);
      Step = 1'b0; tick(8);
   endtask

   task automatic do_reset();
      Reset = 1'b1; tick(2);
      Reset = 1'b0; tick(1);
   endtask

   task automatic wait_run(input string name, input int limit);
      bit seen = 1'b0;
      for (int k = 0; k < limit && !seen; k++) begin
         @(negedge Clock);
         seen = Run;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: no Run within %0d cycles", name, limit);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bit found, h;
      int lat;
      Reset = 1'b0; Step = 1'b0; Auto = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0;
      #1 Reset = 1'b1;
      tick(2);
      check("rst_instr",   32'(Instr),   32'h0);
      check("rst_run",     32'(Run),     32'h0);
      check("rst_pc",      32'(PC),      32'h0);
      check("rst_busy",    32'(Busy),    32'h0);
      check("rst_halted",  32'(Halted),  32'h0);
      check("rst_timeout", 32'(Timeout), 32'h0);
      Reset = 1'b0; cmp_en = 1'b1; resp_en = 1'b1;
      tick(2);
      for (int i = 0; i < 16; i++) wr(i, 16'h0100 + 16'(i));
      wr(0, 16'h2480);
      wr(1, 16'hE000);

      // Free-run two-instruction program ending in halt.
      base = run_cnt; Auto = 1'b1;
      wait_run("auto_run0", 20);
      check("auto_instr0", 32'(Instr), 32'h2480);
      wait_run("auto_run1", 20);
      check("auto_instr1", 32'(Instr), 32'hE000);
      tick(12);
      check("auto_halted", 32'(Halted), 32'h1);
      check("auto_pc",     32'(PC),     32'h2);
      check("auto_runs",   32'(run_cnt - base), 32'd2);
      Auto = 1'b0;

      // Single-step: two presses, then one long press.
      do_reset();
      check("rst2_halted", 32'(Halted), 32'h0);
      check("rst2_pc",     32'(PC),     32'h0);
      wr(1, 16'h4100);
      base = run_cnt;
      pulse_step();
      check("step1_instr", 32'(Instr), 32'h2480);
      pulse_step();
      check("step_runs",   32'(run_cnt - base), 32'd2);
      check("step_instr",  32'(Instr), 32'h4100);
      check("step_pc",     32'(PC),    32'h2);
      base = run_cnt;
      Step = 1'b1; tick(100);
      Step = 1'b0; tick(10);
      check("hold_runs", 32'(run_cnt - base), 32'd1);
      check("hold_pc",   32'(PC),   32'h3);

      // Writes during WAIT are dropped; writes in IDLE are issued next.
      Step = 1'b1;
      wait_run("wwait_run", 10);
      Step = 1'b0;
      tick(1);
      wr(4, 16'hAAAA);
      tick(8);
      pulse_step();
      check("wwait_ignored", 32'(Instr), 32'h0104);
      wr(5, 16'hBBBB);
      pulse_step();
      check("widle_issued", 32'(Instr), 32'hBBBB);
      base = run_cnt;
      WrEn = 1'b1; WrAddr = 4'd6; WrData = 16'hCCCC; Auto = 1'b1;
      tick(1);
      WrEn = 1'b0;
      wait_run("fwd_run", 10);
      check("fwd_instr", 32'(Instr), 32'hCCCC);
      Auto = 1'b0;
      tick(10);
      check("autofall_runs", 32'(run_cnt - base), 32'd1);
      check("autofall_pc",   32'(PC),   32'h7);
      check("autofall_busy", 32'(Busy), 32'h0);

      // PC wraps from 15 to 0 without halting.
      wr(1, 16'hE000);
      Auto = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge Clock);
         found = Run && (PC == 4'hF);
      end
      Auto = 1'b0;
      check("wrap_found", 32'(found), 32'h1);
      tick(10);
      check("wrap_pc",     32'(PC),     32'h0);
      check("wrap_busy",   32'(Busy),   32'h0);
      check("wrap_halted", 32'(Halted), 32'h0);

      // Done never arrives: fault after TIMEOUT waiting cycles.
      do_reset();
      resp_en = 1'b0;
      Step = 1'b1;
      wait_run("to_run", 10);
      Step = 1'b0;
      h = 1'b0; lat = 0;
      for (int k = 1; k <= 300 && !h; k++) begin
         @(negedge Clock);
         if (Halted) begin h = 1'b1; lat = k; end
      end
      check("to_latency", 32'(lat),     32'd256);
      check("to_flag",    32'(Timeout), 32'h1);
      check("to_pc",      32'(PC),      32'h0);
      base = run_cnt;
      tick(5);
      check("to_no_run", 32'(run_cnt - base), 32'd0);

      // Reset mid-WAIT clears outputs at once and keeps memory.
      do_reset();
      Step = 1'b1;
      wait_run("rw_run", 10);
      Step = 1'b0;
      tick(3);
      #3 Reset = 1'b1;
      #1;
      check("rw_instr",   32'(Instr),   32'h0);
      check("rw_run",     32'(Run),     32'h0);
      check("rw_pc",      32'(PC),      32'h0);
      check("rw_busy",    32'(Busy),    32'h0);
      check("rw_halted",  32'(Halted),  32'h0);
      check("rw_timeout", 32'(Timeout), 32'h0);
      tick(2);
      Reset = 1'b0;
      base = run_cnt;
      tick(10);
      check("rw_no_repulse", 32'(run_cnt - base), 32'd0);
      resp_en = 1'b1;
      pulse_step();
      check("rw_readback", 32'(Instr), 32'h2480);
      check("rw_pc_after", 32'(PC),    32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
